// File: rtl/pyon_pkg.sv
// Shared screen geometry, palette and state encoding for the step renderer.
package pyon_pkg;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;
  localparam logic [7:0] BOX_W    = 8'd4;
  localparam logic [6:0] BOX_H    = 7'd3;

  localparam logic [2:0] COLOUR_P1 = 3'b100;
  localparam logic [2:0] COLOUR_P2 = 3'b001;
  localparam logic [2:0] COLOUR_BG = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_CLEAR
  } state_e;

  // Step 0 sits on the bottom three rows; each step climbs one box height.
  function automatic logic [6:0] box_y_top(input logic [5:0] idx);
    logic [7:0] rise;
    rise = 8'd3 * {2'b00, idx};
    return 7'd117 - rise[6:0];
  endfunction

endpackage

// File: rtl/pyon_step_renderer_pixel_scan.sv
// Loadable 2-D raster counter: start loads origin/size, then one pixel per clock, x inner, y outer.
// Registered x/y/active; last is high on the final pixel; a start on that same cycle chains with no gap.
module pixel_scan (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] org_x_i,
  input  logic [6:0] org_y_i,
  input  logic [7:0] width_i,
  input  logic [6:0] height_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       active_o,
  output logic       last_o
);

  logic [7:0] x_q, x_d, org_x_q, org_x_d, end_x_q, end_x_d;
  logic [6:0] y_q, y_d, end_y_q, end_y_d;
  logic       active_q, active_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      org_x_q  <= '0;
      end_x_q  <= '0;
      end_y_q  <= '0;
      active_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      org_x_q  <= org_x_d;
      end_x_q  <= end_x_d;
      end_y_q  <= end_y_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    org_x_d  = org_x_q;
    end_x_d  = end_x_q;
    end_y_d  = end_y_q;
    active_d = active_q;
    if (start_i) begin
      x_d      = org_x_i;
      y_d      = org_y_i;
      org_x_d  = org_x_i;
      end_x_d  = org_x_i + width_i - 8'd1;
      end_y_d  = org_y_i + height_i - 7'd1;
      active_d = 1'b1;
    end else if (active_q) begin
      if (x_q == end_x_q) begin
        x_d = org_x_q;
        if (y_q == end_y_q) begin
          active_d = 1'b0;
        end else begin
          y_d = y_q + 7'd1;
        end
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign active_o = active_q;
  assign last_o   = active_q && (x_q == end_x_q) && (y_q == end_y_q);

endmodule

// File: rtl/pyon_step_renderer.sv
// Turns step events into 4x3 boxes and clear requests into a full-screen wipe, one pixel per clock.
// Box: first pixel 1 cycle after accept, ready again 13 cycles later; ready held low while drawing/clearing.
module pyon_step_renderer
  import pyon_pkg::*;
#(
  parameter int X_BASE_P1   = 40,
  parameter int X_BASE_P2   = 112,
  parameter int LANE_OFFSET = 6,
  parameter int MAX_STEP    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_valid,
  output logic       step_ready,
  input  logic [5:0] step_idx,
  input  logic       step_dir,
  input  logic       step_player,
  input  logic       clear_req,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  state_e     state_q, state_d;
  logic       clear_pend_q, clear_pend_d;
  logic [2:0] colour_q, colour_d;

  logic       start_box, start_clear, scan_last;
  logic [7:0] box_x;
  logic [7:0] org_x, width;
  logic [6:0] org_y, height;
  logic       step_ok;

  assign step_ready = (state_q == ST_IDLE) && !clear_pend_q && !clear_req;
  assign step_ok    = (32'(step_idx) <= MAX_STEP);
  assign box_x      = (step_player ? 8'(X_BASE_P2) : 8'(X_BASE_P1))
                    + (step_dir ? 8'(LANE_OFFSET) : 8'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      clear_pend_q <= 1'b0;
      colour_q     <= COLOUR_BG;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      colour_q     <= colour_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    start_box    = 1'b0;
    start_clear  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          start_clear = 1'b1;
        end else if (step_valid && step_ready && step_ok) begin
          start_box = 1'b1;
        end
      end
      ST_DRAW: begin
        if (clear_req) clear_pend_d = 1'b1;
        if (scan_last) begin
          if (clear_pend_q || clear_req) start_clear = 1'b1;
          else                           state_d     = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (scan_last) begin
          state_d      = ST_IDLE;
          clear_pend_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_clear) state_d = ST_CLEAR;
    if (start_box)   state_d = ST_DRAW;
  end

  // One scanner serves both the box and the full-screen wipe.
  always_comb begin
    org_x    = 8'd0;
    org_y    = 7'd0;
    width    = SCREEN_W;
    height   = SCREEN_H;
    colour_d = colour_q;
    if (start_clear) begin
      colour_d = COLOUR_BG;
    end else if (start_box) begin
      org_x    = box_x;
      org_y    = box_y_top(step_idx);
      width    = BOX_W;
      height   = BOX_H;
      colour_d = step_player ? COLOUR_P2 : COLOUR_P1;
    end
  end

  pixel_scan u_scan (
    .clk      (clk),
    .rst      (reset),
    .start_i  (start_box || start_clear),
    .org_x_i  (org_x),
    .org_y_i  (org_y),
    .width_i  (width),
    .height_i (height),
    .x_o      (x),
    .y_o      (y),
    .active_o (plot),
    .last_o   (scan_last)
  );

  assign colour = colour_q;
  assign busy   = (state_q != ST_IDLE) || clear_pend_q;

endmodule

// File: tb/tb_pyon_step_renderer.sv
// Randomised step/clear stimulus against a geometric model of the box and screen raster.
module tb_pyon_step_renderer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step_valid = 1'b0;
  logic [5:0] step_idx = '0;
  logic       step_dir = 1'b0;
  logic       step_player = 1'b0;
  logic       clear_req = 1'b0;
  logic       step_ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  pyon_step_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_idx    (step_idx),
    .step_dir    (step_dir),
    .step_player (step_player),
    .clear_req   (clear_req),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_x_left(input int player, input int dir);
    return (player != 0 ? 112 : 40) + (dir != 0 ? 6 : 0);
  endfunction

  function automatic int m_y_top(input int idx);
    return 117 - 3 * idx;
  endfunction

  function automatic int m_colour(input int player);
    return (player != 0) ? 1 : 4;
  endfunction

  // Offers one step, then checks the 13 cycles that follow the handshake.
  task automatic run_step(input int idx, input int dir, input int player);
    int  waited;
    bit  draw;
    step_idx    = 6'(idx);
    step_dir    = dir[0];
    step_player = player[0];
    step_valid  = 1'b1;
    waited = 0;
    while (!step_ready && waited < 40000) begin
      @(negedge clk);
      waited++;
    end
    check("step_accept_timeout", 32'(waited < 40000), 1);
    @(posedge clk);
    #1 step_valid = 1'b0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      draw = (idx <= 32) && (i < 12);
      check("step_plot", 32'(plot), 32'(draw));
      check("step_ready", 32'(step_ready), 32'(!draw));
      check("step_busy", 32'(busy), 32'(draw));
      if (draw) begin
        check("box_x", 32'(x), 32'(m_x_left(player, dir) + i % 4));
        check("box_y", 32'(y), 32'(m_y_top(idx) + i / 4));
        check("box_colour", 32'(colour), 32'(m_colour(player)));
      end
    end
  endtask

  // Expects a full-screen wipe to begin at the next falling edge, then IDLE.
  task automatic expect_clear();
    int bad = 0;
    int plots = 0;
    for (int p = 0; p < 160 * 120; p++) begin
      @(negedge clk);
      if (plot) plots++;
      if (!plot || x !== 8'(p % 160) || y !== 7'(p / 160) || colour !== 3'b000 || step_ready)
        bad++;
    end
    check("clear_plot_count", 32'(plots), 19200);
    check("clear_pixel_errs", 32'(bad), 0);
    @(negedge clk);
    check("clear_done_plot", 32'(plot), 0);
    check("clear_done_ready", 32'(step_ready), 1);
    check("clear_done_busy", 32'(busy), 0);
  endtask

  initial begin
    int low_cnt, plot_cnt;

    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_plot", 32'(plot), 0);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_colour", 32'(colour), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(step_ready), 1);
    check("post_rst_plot", 32'(plot), 0);

    run_step(0, 0, 0);
    run_step(32, 1, 1);
    run_step(33, 0, 0);
    run_step(0, 1, 1);
    run_step(63, 1, 0);

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_step(int'($urandom_range(0, 40)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    // Clear requested on the 5th box pixel: box finishes, wipe follows with no gap.
    step_idx = 6'd10; step_dir = 1'b0; step_player = 1'b1; step_valid = 1'b1;
    @(posedge clk);
    #1 step_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("pend_box_plot", 32'(plot), 1);
      check("pend_box_x", 32'(x), 32'(m_x_left(1, 0) + i % 4));
      check("pend_box_y", 32'(y), 32'(m_y_top(10) + i / 4));
      if (i > 4) begin
        check("pend_busy", 32'(busy), 1);
        check("pend_ready", 32'(step_ready), 0);
      end
      if (i == 4) clear_req = 1'b1;
      if (i == 5) clear_req = 1'b0;
    end
    expect_clear();

    // Clear and step together: clear wins, held step goes in afterwards.
    @(posedge clk);
    #1;
    clear_req = 1'b1; step_valid = 1'b1;
    step_idx = 6'd5; step_dir = 1'b1; step_player = 1'b0;
    #1 check("collide_ready", 32'(step_ready), 0);
    @(posedge clk);
    #1 clear_req = 1'b0;
    low_cnt = 0;
    plot_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (step_ready) break;
      low_cnt++;
      if (plot) plot_cnt++;
    end
    check("collide_ready_low", 32'(low_cnt), 19200);
    check("collide_plots", 32'(plot_cnt), 19200);
    run_step(5, 1, 0);

    // Reset in the middle of a wipe.
    clear_req = 1'b1;
    @(posedge clk);
    #1 clear_req = 1'b0;
    repeat (1000) @(negedge clk);
    check("midclear_x", 32'(x), 32'(999 % 160));
    check("midclear_y", 32'(y), 32'(999 / 160));
    #1 reset = 1'b1;
    #1;
    check("arst_plot", 32'(plot), 0);
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_arst_ready", 32'(step_ready), 1);
      check("after_arst_plot", 32'(plot), 0);
    end
    run_step(17, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
